// File: rtl/pixel_stream_scheduler_if.sv
// Requester, frame-buffer and sender signals of the pixel stream scheduler.
// slave = scheduler side, master = requester/BRAM/sender side.
interface pixel_stream_scheduler_if #(
  parameter int PIX_W  = 12,
  parameter int ADDR_W = 17
);
  logic [1:0]        req;
  logic [ADDR_W-1:0] num_pixels;
  logic              abort;
  logic [1:0]        grant;
  logic              busy;
  logic              done;
  logic              aborted;
  logic [ADDR_W-1:0] rd_addr;
  logic [PIX_W-1:0]  rd_data;
  logic [PIX_W-1:0]  tx_pixel;
  logic              tx_valid;
  logic              tx_ready;

  modport slave (
    input  req, num_pixels, abort, rd_data, tx_ready,
    output grant, busy, done, aborted, rd_addr, tx_pixel, tx_valid
  );

  modport master (
    output req, num_pixels, abort, rd_data, tx_ready,
    input  grant, busy, done, aborted, rd_addr, tx_pixel, tx_valid
  );
endinterface

// File: rtl/pixel_stream_scheduler.sv
// Round-robin frame arbiter streaming BRAM pixels to the UART sender.
// Define PIXEL_SYNC_HEADER_EN to send SYNC_WORD before each frame.
module pixel_stream_scheduler #(
  parameter int PIX_W  = 12,
  parameter int ADDR_W = 17
`ifdef PIXEL_SYNC_HEADER_EN
  , parameter logic [PIX_W-1:0] SYNC_WORD = 'hFFF
`endif
) (
  input logic clk,
  input logic reset,
  pixel_stream_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LOAD,
    S_PRESENT,
    S_DONE
`ifdef PIXEL_SYNC_HEADER_EN
    , S_HDR
`endif
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [PIX_W-1:0]  tx_pixel_q, tx_pixel_d;
  logic              last_q, last_d;
  logic              aborted_q, aborted_d;
  logic              winner;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      cnt_q      <= '0;
      rd_addr_q  <= '0;
      tx_pixel_q <= '0;
      last_q     <= 1'b1;
      aborted_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      cnt_q      <= cnt_d;
      rd_addr_q  <= rd_addr_d;
      tx_pixel_q <= tx_pixel_d;
      last_q     <= last_d;
      aborted_q  <= aborted_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    cnt_d      = cnt_q;
    rd_addr_d  = rd_addr_q;
    tx_pixel_d = tx_pixel_q;
    last_d     = last_q;
    aborted_d  = 1'b0;
    // on a tie the requester that did not win last time goes next
    winner = (bus.req == 2'b11) ? ~last_q : bus.req[1];
    if (state_q != S_IDLE && bus.abort) begin
      state_d   = S_IDLE;
      grant_d   = '0;
      aborted_d = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (|bus.req) begin
            grant_d   = winner ? 2'b10 : 2'b01;
            cnt_d     = bus.num_pixels;
            rd_addr_d = '0;
            last_d    = winner;
`ifdef PIXEL_SYNC_HEADER_EN
            tx_pixel_d = SYNC_WORD;
            state_d    = S_HDR;
`else
            state_d = (bus.num_pixels == '0) ? S_DONE : S_READ;
`endif
          end
        end
`ifdef PIXEL_SYNC_HEADER_EN
        S_HDR: begin
          if (bus.tx_ready)
            state_d = (cnt_q == '0) ? S_DONE : S_READ;
        end
`endif
        S_READ: state_d = S_LOAD;
        S_LOAD: begin
          tx_pixel_d = bus.rd_data;
          state_d    = S_PRESENT;
        end
        S_PRESENT: begin
          if (bus.tx_ready) begin
            cnt_d = cnt_q - ADDR_W'(1);
            // address stays on the last pixel rather than running past it
            if (cnt_q == ADDR_W'(1)) begin
              state_d = S_DONE;
            end else begin
              rd_addr_d = rd_addr_q + ADDR_W'(1);
              state_d   = S_READ;
            end
          end
        end
        S_DONE: begin
          grant_d = '0;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign bus.grant    = grant_q;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = (state_q == S_DONE) && !bus.abort;
  assign bus.aborted  = aborted_q;
  assign bus.rd_addr  = rd_addr_q;
  assign bus.tx_pixel = tx_pixel_q;
`ifdef PIXEL_SYNC_HEADER_EN
  assign bus.tx_valid = (state_q == S_PRESENT) || (state_q == S_HDR);
`else
  assign bus.tx_valid = (state_q == S_PRESENT);
`endif

endmodule

// File: tb/tb_pixel_stream_scheduler.sv
// Randomized frame traffic against a queue-based model of the scheduler.
// Checks arbitration, pixel order, latency, hold, abort and reset.
module tb_pixel_stream_scheduler;

  logic clk;
  logic reset;
  logic [11:0] mem [0:63];
  int n_cmp;
  int n_err;
  bit exp_last;

`ifdef PIXEL_SYNC_HEADER_EN
  localparam int FIRST_V = 0;
`else
  localparam int FIRST_V = 2;
`endif

  pixel_stream_scheduler_if #(.PIX_W(12), .ADDR_W(17)) bus ();

  pixel_stream_scheduler #(.PIX_W(12), .ADDR_W(17)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) bus.rd_data <= mem[bus.rd_addr[5:0]];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_grant"}, bus.grant, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_abt"}, bus.aborted, 0);
    chk({tag, "_valid"}, bus.tx_valid, 0);
    chk({tag, "_addr"}, bus.rd_addr, 0);
    chk({tag, "_pix"}, bus.tx_pixel, 0);
  endtask

  // Called on a negedge with the scheduler idle; returns on a negedge.
  task automatic run_frame(input logic [1:0] pat, input int n,
                           input int mode, input int abort_at);
    logic [11:0] q[$];
    logic [11:0] held;
    logic [1:0] eg;
    int gw, k, nx, last_x, wcnt;
    bit fin, ab, hold, seen_v;
    gw = (pat == 2'b11) ? (exp_last ? 0 : 1) : (pat[1] ? 1 : 0);
    eg = (gw == 1) ? 2'b10 : 2'b01;
    q = {};
`ifdef PIXEL_SYNC_HEADER_EN
    q.push_back(12'hFFF);
`endif
    for (int i = 0; i < n; i++) q.push_back(mem[i]);
    bus.req = pat;
    bus.num_pixels = 17'(n);
    @(negedge clk);
    chk("grant_first", bus.grant, eg);
    chk("addr_start", bus.rd_addr, 0);
    exp_last = (gw == 1);
    bus.req = pat & ~eg;
    bus.num_pixels = 17'($urandom_range(0, 50));
    k = 0; nx = 0; last_x = -1; wcnt = 0;
    fin = 0; ab = 0; hold = 0; seen_v = 0; held = '0;
    while (!fin && k < 800) begin
      if (k > 0) @(negedge clk);
      if (ab) begin
        chk("ab_pulse", bus.aborted, 1);
        chk("ab_valid", bus.tx_valid, 0);
        chk("ab_grant", bus.grant, 0);
        chk("ab_busy", bus.busy, 0);
        chk("ab_done", bus.done, 0);
        bus.abort = 1'b0;
        fin = 1;
      end else begin
        chk("grant_hold", bus.grant, eg);
        chk("no_abort", bus.aborted, 0);
        if (hold) begin
          chk("hold_valid", bus.tx_valid, 1);
          chk("hold_pix", bus.tx_pixel, held);
        end
        if (bus.tx_valid && !seen_v) begin
          seen_v = 1;
          chk("first_valid", k, FIRST_V);
        end
        if (bus.done) begin
          chk("done_time", k, last_x + 1);
          chk("done_left", q.size(), 0);
          fin = 1;
        end else begin
          case (mode)
            0: bus.tx_ready = 1'b1;
            1: bus.tx_ready = 1'($urandom_range(0, 1));
            default: bus.tx_ready = (wcnt >= 20);
          endcase
          hold = 0;
          if (bus.tx_valid) begin
            if (nx == abort_at) begin
              bus.abort = 1'b1;
              bus.tx_ready = 1'b0;
              ab = 1;
            end else if (bus.tx_ready) begin
              chk("valid_extra", (q.size() > 0), 1);
              if (q.size() > 0) chk("pixel", bus.tx_pixel, q.pop_front());
              nx++;
              last_x = k;
              wcnt = 0;
            end else begin
              hold = 1;
              held = bus.tx_pixel;
              wcnt++;
            end
          end
        end
      end
      k++;
    end
    bus.tx_ready = 1'b0;
    if (!fin) begin
      chk("frame_timeout", 0, 1);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      @(negedge clk);
    end else if (!ab) begin
      @(negedge clk);
      chk("idle_busy", bus.busy, 0);
      chk("idle_grant", bus.grant, 0);
      chk("idle_done", bus.done, 0);
      chk("idle_valid", bus.tx_valid, 0);
    end
  endtask

  initial begin
    int n, ab;
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < 64; i++) mem[i] = 12'(i + 1);
    reset = 1'b0;
    bus.req = '0;
    bus.num_pixels = '0;
    bus.abort = 1'b0;
    bus.tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_rst("reset");
    reset = 1'b1;
    exp_last = 1'b1;
    @(negedge clk);

    run_frame(2'b01, 4, 0, -1);
    repeat (3) run_frame(2'b11, 2, 0, -1);
    run_frame(2'b01, 3, 2, -1);
    run_frame(2'b10, 4, 0, 1);
    run_frame(2'b10, 4, 0, -1);
    run_frame(2'b01, 0, 0, -1);
    run_frame(2'b10, 0, 1, -1);

    for (int i = 0; i < 64; i++) mem[i] = 12'($urandom);
    for (int f = 0; f < 40; f++) begin
      n = $urandom_range(0, 7);
      ab = (n > 0 && $urandom_range(0, 5) == 0) ? $urandom_range(0, n - 1) : -1;
      run_frame(2'($urandom_range(1, 3)), n, $urandom_range(0, 1), ab);
    end

    bus.req = 2'b01;
    bus.num_pixels = 17'd5;
    bus.tx_ready = 1'b1;
    repeat (9) @(negedge clk);
    reset = 1'b0;
    bus.req = '0;
    @(negedge clk);
    chk_rst("midrst");
    reset = 1'b1;
    bus.tx_ready = 1'b0;
    @(negedge clk);
    chk_rst("postrst");
    exp_last = 1'b1;
    run_frame(2'b11, 2, 0, -1);

    bus.req = '0;
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
